data_collector_unit: RTL and testbench

Single-channel data collector for verification environments. Samples a monitored vector every clock while enabled and stores a sample only when the value changes, together with a free-running timestamp. Samples go into an internal FIFO that the testbench sequencer drains through a simple read port. Each monitored bus in a bench gets one instance, for example {clk, rst_n, start, en_load, data[15:0]}.

---
 rtl/data_collector_unit.sv | 172 +++++++++++++++++
 tb/tb_data_collector_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_collector_unit.sv
// ============================================================================
// data_collector_unit
// ----------------------------------------------------------------------------
// Single-channel change-detecting sample collector. While enabled, the
// monitored vector is compared against the last captured value every clock;
// a new value (or the first enabled cycle after enable rises / after a
// clear) is captured together with a free-running timestamp into a FIFO
// that is drained through a simple pop-style read port.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   i_data      monitored vector
//   i_en        collection enable (level)
//   i_clr       synchronous flush of FIFO and status
//   i_rd        read request (pop one entry)
//   o_rd_valid  one-cycle pulse: o_rd_data / o_rd_ts valid
//   o_rd_data   popped sample value
//   o_rd_ts     timestamp of popped sample
//   o_count     entries currently stored
//   o_empty     count == 0
//   o_full      count == G_DEPTH
//   o_overflow  sticky: a capture was dropped
// ============================================================================
module data_collector_unit #(
    parameter int G_DATA_WIDTH = 20,
    parameter int G_DEPTH      = 16,
    parameter int G_TS_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [G_DATA_WIDTH-1:0]      i_data,
    input  logic                         i_en,
    input  logic                         i_clr,
    input  logic                         i_rd,
    output logic                         o_rd_valid,
    output logic [G_DATA_WIDTH-1:0]      o_rd_data,
    output logic [G_TS_WIDTH-1:0]        o_rd_ts,
    output logic [$clog2(G_DEPTH):0]     o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_overflow
);

    localparam int AW = $clog2(G_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = G_DATA_WIDTH + G_TS_WIDTH;

    localparam logic [CW-1:0]         DEPTH_C = CW'(G_DEPTH);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [AW-1:0]         PTR_ONE = AW'(1);
    localparam logic [G_TS_WIDTH-1:0] TS_ONE  = G_TS_WIDTH'(1);

    // Entry storage; contents need no reset, only pointers/count define validity.
    logic [EW-1:0] mem [G_DEPTH];

    logic [G_TS_WIDTH-1:0]   ts_reg;
    logic [G_DATA_WIDTH-1:0] last_reg,  last_next;
    logic                    first_reg, first_next;
    logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]           count_reg, count_next;
    logic                    empty_reg, full_reg;
    logic                    ovf_reg, ovf_next;
    logic                    rd_valid_reg;
    logic [G_DATA_WIDTH-1:0] rd_data_reg;
    logic [G_TS_WIDTH-1:0]   rd_ts_reg;

    logic capture;
    logic rd_accept;
    logic wr_accept;
    logic drop;

    always_comb begin
        capture     = i_en && (first_reg || (i_data != last_reg));
        // Clear wins over everything in its cycle. An empty FIFO ignores the
        // read, so a same-cycle write into an empty FIFO is a plain write.
        rd_accept   = i_rd && !empty_reg && !i_clr;
        // A full FIFO still accepts a write when a pop frees the slot; the
        // slot being written is the one being read, and the read sees the
        // old contents because the memory read is registered.
        wr_accept   = capture && !i_clr && (!full_reg || rd_accept);
        drop        = capture && !i_clr && !wr_accept;

        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        ovf_next    = ovf_reg;
        last_next   = last_reg;
        first_next  = first_reg;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + CNT_ONE;
        end else if (!wr_accept && rd_accept) begin
            count_next = count_reg - CNT_ONE;
        end

        // A dropped capture still becomes the new reference value so that
        // the same value is not reported again once space frees up.
        if (capture && !i_clr) begin
            last_next  = i_data;
            first_next = 1'b0;
        end
        if (drop) begin
            ovf_next = 1'b1;
        end

        if (!i_en) begin
            first_next = 1'b1;
        end

        if (i_clr) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            ovf_next    = 1'b0;
            first_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_reg       <= '0;
            last_reg     <= '0;
            first_reg    <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_ts_reg    <= '0;
        end else begin
            ts_reg       <= ts_reg + TS_ONE;
            last_reg     <= last_next;
            first_reg    <= first_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == DEPTH_C);
            ovf_reg      <= ovf_next;
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                {rd_data_reg, rd_ts_reg} <= mem[rd_ptr_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= {i_data, ts_reg};
        end
    end

    assign o_rd_valid = rd_valid_reg;
    assign o_rd_data  = rd_data_reg;
    assign o_rd_ts    = rd_ts_reg;
    assign o_count    = count_reg;
    assign o_empty    = empty_reg;
    assign o_full     = full_reg;
    assign o_overflow = ovf_reg;

endmodule

// File: tb/tb_data_collector_unit.sv
// ============================================================================
// tb_data_collector_unit
// ----------------------------------------------------------------------------
// Directed scenarios plus a randomized run of data_collector_unit, checked
// against a queue-based reference model of the collector.
// ============================================================================
module tb_data_collector_unit;

    localparam int DW  = 20;
    localparam int DEP = 16;
    localparam int TSW = 32;
    localparam int CW  = $clog2(DEP) + 1;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  i_data;
    logic           i_en;
    logic           i_clr;
    logic           i_rd;
    logic           o_rd_valid;
    logic [DW-1:0]  o_rd_data;
    logic [TSW-1:0] o_rd_ts;
    logic [CW-1:0]  o_count;
    logic           o_empty;
    logic           o_full;
    logic           o_overflow;

    int n_vec;
    int n_err;

    data_collector_unit #(
        .G_DATA_WIDTH(DW),
        .G_DEPTH     (DEP),
        .G_TS_WIDTH  (TSW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .i_en      (i_en),
        .i_clr     (i_clr),
        .i_rd      (i_rd),
        .o_rd_valid(o_rd_valid),
        .o_rd_data (o_rd_data),
        .o_rd_ts   (o_rd_ts),
        .o_count   (o_count),
        .o_empty   (o_empty),
        .o_full    (o_full),
        .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW+TSW-1:0] m_q[$];
    logic [TSW-1:0]    m_ts;
    logic              m_first;
    logic [DW-1:0]     m_last;
    logic              m_ovf;
    logic              m_rv;
    logic [DW-1:0]     m_rdata;
    logic [TSW-1:0]    m_rts;
    bit                m_do_rd;
    bit                m_do_cap;
    bit                m_was_full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ts    = '0;
            m_first = 1'b1;
            m_last  = '0;
            m_ovf   = 1'b0;
            m_rv    = 1'b0;
            m_rdata = '0;
            m_rts   = '0;
        end else begin
            m_rv = 1'b0;
            if (i_clr) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_first = 1'b1;
            end else begin
                m_do_rd    = i_rd && (m_q.size() > 0);
                m_do_cap   = i_en && (m_first || (i_data != m_last));
                m_was_full = (m_q.size() == DEP);
                if (m_do_rd) begin
                    {m_rdata, m_rts} = m_q.pop_front();
                    m_rv = 1'b1;
                end
                if (m_do_cap) begin
                    if (!m_was_full || m_do_rd) m_q.push_back({i_data, m_ts});
                    else                        m_ovf = 1'b1;
                    m_last  = i_data;
                    m_first = 1'b0;
                end
                if (!i_en) m_first = 1'b1;
            end
            m_ts = m_ts + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_data = '0; i_en = 1'b0; i_clr = 1'b0; i_rd = 1'b0;
        cyc(); cyc();
        n_vec++; if (o_count !== 0)     begin n_err++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        n_vec++; if (o_empty !== 1'b1)  begin n_err++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        n_vec++; if (o_full !== 1'b0)   begin n_err++; $display("FAIL reset_full got=%b exp=0", o_full); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
        n_vec++; if (o_rd_valid !== 1'b0 || o_rd_data !== '0 || o_rd_ts !== '0)
            begin n_err++; $display("FAIL reset_rd got v=%b d=%h ts=%0d exp 0/0/0", o_rd_valid, o_rd_data, o_rd_ts); end
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_hold();
        logic [TSW-1:0] t0;
        i_en = 1'b1; i_data = 20'h00ABC;
        t0 = m_ts;
        repeat (10) cyc();
        n_vec++; if (o_count !== 1) begin n_err++; $display("FAIL hold_count got=%0d exp=1", o_count); end
        i_rd = 1'b1; cyc(); i_rd = 1'b0;
        n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== 20'h00ABC || o_rd_ts !== t0)
            begin n_err++; $display("FAIL hold_read got v=%b d=%h ts=%0d exp v=1 d=00abc ts=%0d", o_rd_valid, o_rd_data, o_rd_ts, t0); end
        $display("hold read d=%h ts=%0d", o_rd_data, o_rd_ts);
        n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL hold_empty got=%b exp=1", o_empty); end
        cyc();
        n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL hold_pulse got=%b exp=0", o_rd_valid); end
    endtask

    task automatic test_sequence();
        logic [DW-1:0]  seq [6] = '{1, 1, 2, 2, 2, 3};
        logic [DW-1:0]  exp_d [3] = '{1, 2, 3};
        int             exp_off [3] = '{0, 2, 5};
        logic [TSW-1:0] t0;
        i_en = 1'b0; i_clr = 1'b1; cyc(); i_clr = 1'b0;
        i_en = 1'b1;
        t0 = m_ts;
        for (int j = 0; j < 6; j++) begin
            i_data = seq[j];
            cyc();
        end
        i_en = 1'b0;
        n_vec++; if (o_count !== 3) begin n_err++; $display("FAIL seq_count got=%0d exp=3", o_count); end
        i_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_vec++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d[k] || o_rd_ts !== t0 + TSW'(exp_off[k]))
                begin n_err++; $display("FAIL seq_read%0d got v=%b d=%h ts=%0d exp d=%h ts=%0d", k, o_rd_valid, o_rd_data, o_rd_ts, exp_d[k], t0 + TSW'(exp_off[k])); end
            $display("seq read d=%h ts=%0d", o_rd_data, o_rd_ts);
        end
        i_rd = 1'b0;
    endtask

    task automatic test_overflow();
        logic [TSW-1:0] t0;
        i_en = 1'b0; i_clr = 1'b1; cyc(); i_clr = 1'b0;
        i_en = 1'b1;
        t0 = m_ts;
        for (int j = 0; j < DEP + 3; j++) begin
            i_data = DW'(100 + j);
            cyc();
        end
        i_en = 1'b0;
        n_vec++; if (o_full !== 1'b1 || o_count !== DEP || o_overflow !== 1'b1)
            begin n_err++; $display("FAIL ovf_status got full=%b cnt=%0d ovf=%b exp 1/16/1", o_full, o_count, o_overflow); end
        i_rd = 1'b1;
        for (int k = 0; k < DEP; k++) begin
            cyc();
            n_vec++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== DW'(100 + k) || o_rd_ts !== t0 + TSW'(k))
                begin n_err++; $display("FAIL ovf_read%0d got v=%b d=%h ts=%0d exp d=%h ts=%0d", k, o_rd_valid, o_rd_data, o_rd_ts, DW'(100 + k), t0 + TSW'(k)); end
            $display("ovf read d=%h ts=%0d", o_rd_data, o_rd_ts);
        end
        i_rd = 1'b0;
        cyc();
        n_vec++; if (o_empty !== 1'b1 || o_rd_valid !== 1'b0)
            begin n_err++; $display("FAIL ovf_drained got empty=%b v=%b exp 1/0", o_empty, o_rd_valid); end
    endtask

    task automatic test_full_rdwr();
        logic [TSW-1:0] t0;
        i_en = 1'b0; i_clr = 1'b1; cyc(); i_clr = 1'b0;
        i_en = 1'b1;
        t0 = m_ts;
        for (int j = 0; j < DEP; j++) begin
            i_data = DW'(200 + j);
            cyc();
        end
        n_vec++; if (o_full !== 1'b1 || o_overflow !== 1'b0)
            begin n_err++; $display("FAIL rdwr_fill got full=%b ovf=%b exp 1/0", o_full, o_overflow); end
        i_data = 20'h00999; i_rd = 1'b1;
        cyc();
        n_vec++; if (o_count !== DEP || o_overflow !== 1'b0 || o_full !== 1'b1)
            begin n_err++; $display("FAIL rdwr_status got cnt=%0d ovf=%b full=%b exp 16/0/1", o_count, o_overflow, o_full); end
        n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== DW'(200))
            begin n_err++; $display("FAIL rdwr_first got v=%b d=%h exp 1/000c8", o_rd_valid, o_rd_data); end
        for (int k = 1; k <= DEP; k++) begin
            cyc();
            n_vec++;
            if (k < DEP) begin
                if (o_rd_valid !== 1'b1 || o_rd_data !== DW'(200 + k))
                    begin n_err++; $display("FAIL rdwr_read%0d got v=%b d=%h exp %h", k, o_rd_valid, o_rd_data, DW'(200 + k)); end
            end else begin
                if (o_rd_valid !== 1'b1 || o_rd_data !== 20'h00999 || o_rd_ts !== t0 + TSW'(DEP))
                    begin n_err++; $display("FAIL rdwr_last got v=%b d=%h ts=%0d exp 00999 ts=%0d", o_rd_valid, o_rd_data, o_rd_ts, t0 + TSW'(DEP)); end
            end
            $display("rdwr read d=%h ts=%0d", o_rd_data, o_rd_ts);
        end
        i_rd = 1'b0; i_en = 1'b0;
        cyc();
    endtask

    task automatic test_enable_toggle();
        i_en = 1'b0; i_clr = 1'b1; cyc(); i_clr = 1'b0;
        i_data = 20'h5;
        i_en = 1'b1; cyc(); cyc();
        i_en = 1'b0; cyc(); cyc();
        i_en = 1'b1; cyc(); cyc();
        n_vec++; if (o_count !== 2) begin n_err++; $display("FAIL toggle_count got=%0d exp=2", o_count); end
        i_rd = 1'b1; cyc(); i_rd = 1'b0;
        n_vec++; if (o_rd_valid !== 1'b1 || o_rd_data !== 20'h5)
            begin n_err++; $display("FAIL toggle_read got v=%b d=%h exp 1/00005", o_rd_valid, o_rd_data); end
        $display("toggle read d=%h ts=%0d", o_rd_data, o_rd_ts);
        // Clear with a same-cycle read and a pending entry: clear wins.
        i_en = 1'b0; i_clr = 1'b1; i_rd = 1'b1;
        cyc();
        i_clr = 1'b0; i_rd = 1'b0;
        n_vec++; if (o_count !== 0 || o_overflow !== 1'b0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0)
            begin n_err++; $display("FAIL toggle_clr got cnt=%0d ovf=%b empty=%b v=%b exp 0/0/1/0", o_count, o_overflow, o_empty, o_rd_valid); end
    endtask

    task automatic test_mid_reset();
        i_en = 1'b0; i_clr = 1'b1; cyc(); i_clr = 1'b0;
        i_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            i_data = DW'($urandom_range(0, 255) * 8 + j);
            cyc();
        end
        n_vec++; if (o_count !== 5) begin n_err++; $display("FAIL midrst_pre got=%0d exp=5", o_count); end
        i_data = 20'h12345;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (o_count !== 0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0)
            begin n_err++; $display("FAIL midrst_state got cnt=%0d empty=%b v=%b exp 0/1/0", o_count, o_empty, o_rd_valid); end
        cyc();
        rst = 1'b0; i_en = 1'b0; i_rd = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_vec++; if (o_rd_valid !== 1'b0 || o_empty !== 1'b1)
                begin n_err++; $display("FAIL midrst_rd%0d got v=%b empty=%b exp 0/1", k, o_rd_valid, o_empty); end
        end
        i_rd = 1'b0;
        $display("mid reset done");
    endtask

    task automatic test_random();
        int n_reads;
        n_reads = 0;
        for (int c = 0; c < 600; c++) begin
            i_en   = ($urandom_range(0, 99) < 85);
            i_data = ($urandom_range(0, 9) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
            i_rd   = ($urandom_range(0, 99) < 30);
            i_clr  = ($urandom_range(0, 99) < 2);
            cyc();
            n_vec++;
            if (o_count !== CW'(m_q.size()) || o_empty !== (m_q.size() == 0) ||
                o_full !== (m_q.size() == DEP) || o_overflow !== m_ovf)
                begin n_err++; $display("FAIL rand_status c=%0d got cnt=%0d e=%b f=%b ovf=%b exp cnt=%0d ovf=%b", c, o_count, o_empty, o_full, o_overflow, m_q.size(), m_ovf); end
            n_vec++;
            if (o_rd_valid !== m_rv || (m_rv && (o_rd_data !== m_rdata || o_rd_ts !== m_rts)))
                begin n_err++; $display("FAIL rand_read c=%0d got v=%b d=%h ts=%0d exp v=%b d=%h ts=%0d", c, o_rd_valid, o_rd_data, o_rd_ts, m_rv, m_rdata, m_rts); end
            if (m_rv) n_reads++;
        end
        i_en = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
        $display("random run reads=%0d", n_reads);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_hold();
        test_sequence();
        test_overflow();
        test_full_rdwr();
        test_enable_toggle();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
